// File: rtl/onehot_ring_seq_if.sv
// Step/load request and ring-state bundle for onehot_ring_seq.
// The master drives requests and the slave (the sequencer) returns state.
interface onehot_ring_seq_if #(
  parameter int N = 3
) ();
  localparam int IW = $clog2(N);

  logic          step_in;
  logic          dir;
  logic          load;
  logic [IW-1:0] load_idx;
  logic [N-1:0]  state;
  logic [IW-1:0] idx;
  logic          wrap;
  logic          err;

  modport master (
    output step_in,
    output dir,
    output load,
    output load_idx,
    input  state,
    input  idx,
    input  wrap,
    input  err
  );

  modport slave (
    input  step_in,
    input  dir,
    input  load,
    input  load_idx,
    output state,
    output idx,
    output wrap,
    output err
  );
endinterface

// File: rtl/onehot_ring_seq.sv
// One-hot ring sequencer: synchronised step, direct load, binary index,
// wrap pulse and recovery from corrupted (non one-hot) state.
module onehot_ring_seq #(
  parameter int N         = 3,
  parameter bit EDGE_MODE = 1'b1,
  parameter int RESET_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  onehot_ring_seq_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam logic [N-1:0]  RST_STATE = N'(1) << RESET_IDX;
  localparam logic [IW-1:0] RST_IDX   = IW'(RESET_IDX);
  localparam logic [IW-1:0] TOP_IDX   = IW'(N - 1);
  localparam logic [IW:0]   N_LIM     = (IW + 1)'(N);

  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic [N-1:0]  r_state;
  logic [IW-1:0] r_idx;
  logic          r_wrap;
  logic          r_err;

  logic          w_adv;
  logic          w_onehot;
  logic          w_load_ok;
  logic          w_at_top;
  logic          w_at_bot;
  logic [N-1:0]  w_rot_up;
  logic [N-1:0]  w_rot_dn;
  logic [IW-1:0] w_idx_up;
  logic [IW-1:0] w_idx_dn;
  logic [N-1:0]  w_state_nx;
  logic [IW-1:0] w_idx_nx;
  logic          w_wrap_nx;
  logic          w_err_nx;

  assign w_adv = EDGE_MODE ? (r_s2 & ~r_s3) : r_s2;

  // x & (x-1) clears the lowest set bit: zero iff at most one bit set
  assign w_onehot = (r_state != '0) &&
                    ((r_state & (r_state - N'(1))) == '0);

  assign w_load_ok = {1'b0, bus.load_idx} < N_LIM;

  assign w_at_top = r_state[N-1];
  assign w_at_bot = r_state[0];

  assign w_rot_up = {r_state[N-2:0], r_state[N-1]};
  assign w_rot_dn = {r_state[0], r_state[N-1:1]};

  assign w_idx_up = (r_idx == TOP_IDX) ? '0 : r_idx + 1'b1;
  assign w_idx_dn = (r_idx == '0) ? TOP_IDX : r_idx - 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_wrap_nx  = 1'b0;
    w_err_nx   = 1'b0;
    unique case (1'b1)
      !w_onehot: begin
        w_state_nx = RST_STATE;
        w_idx_nx   = RST_IDX;
        w_err_nx   = 1'b1;
      end
      w_onehot && bus.load && w_load_ok: begin
        w_state_nx = N'(1) << bus.load_idx;
        w_idx_nx   = bus.load_idx;
      end
      w_onehot && bus.load && !w_load_ok: begin
        w_err_nx = 1'b1;
      end
      w_onehot && !bus.load && w_adv && bus.dir: begin
        w_state_nx = w_rot_up;
        w_idx_nx   = w_idx_up;
        w_wrap_nx  = w_at_top;
      end
      w_onehot && !bus.load && w_adv && !bus.dir: begin
        w_state_nx = w_rot_dn;
        w_idx_nx   = w_idx_dn;
        w_wrap_nx  = w_at_bot;
      end
      default: begin
        w_state_nx = r_state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_state <= RST_STATE;
      r_idx   <= RST_IDX;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_s1    <= bus.step_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_wrap  <= w_wrap_nx;
      r_err   <= w_err_nx;
    end
  end

  assign bus.state = r_state;
  assign bus.idx   = r_idx;
  assign bus.wrap  = r_wrap;
  assign bus.err   = r_err;
endmodule

// File: tb/tb_onehot_ring_seq.sv
// Bench for onehot_ring_seq: three configurations against an
// integer-position reference model plus directed corner sequences.
module tb_onehot_ring_seq;
  logic clk;
  logic rst;

  onehot_ring_seq_if #(.N(3)) b3();
  onehot_ring_seq_if #(.N(4)) b4();
  onehot_ring_seq_if #(.N(5)) b5();

  onehot_ring_seq #(.N(3), .EDGE_MODE(1'b1), .RESET_IDX(0)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave));
  onehot_ring_seq #(.N(4), .EDGE_MODE(1'b1), .RESET_IDX(2)) u4 (
    .clk(clk), .rst(rst), .bus(b4.slave));
  onehot_ring_seq #(.N(5), .EDGE_MODE(1'b0), .RESET_IDX(0)) u5 (
    .clk(clk), .rst(rst), .bus(b5.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int p;
    bit h1, h2, h3;
    bit wrap, err;
  } mdl_t;

  typedef struct {
    bit st, dr, ld;
    int li;
    int es, ei;
    bit ew, ee;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  bit   chk4  = 1'b1;
  mdl_t m3, m4, m5;
  vec_t tbl[14];

  function automatic mdl_t minit(int ri);
    mdl_t r;
    r.p = ri;
    r.h1 = 0; r.h2 = 0; r.h3 = 0;
    r.wrap = 0; r.err = 0;
    return r;
  endfunction

  // h1..h3 are the step samples from 1..3 edges ago
  function automatic mdl_t mstep(mdl_t m, int n, bit em,
                                 bit st, bit dr, bit ld, int li);
    mdl_t r;
    bit adv;
    r = m;
    adv = em ? (m.h2 && !m.h3) : m.h2;
    r.h1 = st; r.h2 = m.h1; r.h3 = m.h2;
    r.wrap = 0; r.err = 0;
    if (ld) begin
      if (li < n) r.p = li;
      else r.err = 1;
    end else if (adv) begin
      if (dr) begin
        r.wrap = (m.p == n - 1);
        r.p = (m.p + 1) % n;
      end else begin
        r.wrap = (m.p == 0);
        r.p = (m.p + n - 1) % n;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m3 <= minit(0);
      m4 <= minit(2);
      m5 <= minit(0);
    end else begin
      m3 <= mstep(m3, 3, 1, b3.step_in, b3.dir, b3.load,
                  int'(b3.load_idx));
      m4 <= mstep(m4, 4, 1, b4.step_in, b4.dir, b4.load,
                  int'(b4.load_idx));
      m5 <= mstep(m5, 5, 0, b5.step_in, b5.dir, b5.load,
                  int'(b5.load_idx));
    end
  end

  task automatic chk(string nm, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("u3.state", int'(b3.state), 1 << m3.p);
    chk("u3.idx", int'(b3.idx), m3.p);
    chk("u3.wrap", int'(b3.wrap), int'(m3.wrap));
    chk("u3.err", int'(b3.err), int'(m3.err));
    chk("u5.state", int'(b5.state), 1 << m5.p);
    chk("u5.idx", int'(b5.idx), m5.p);
    chk("u5.wrap", int'(b5.wrap), int'(m5.wrap));
    chk("u5.err", int'(b5.err), int'(m5.err));
    if (chk4) begin
      chk("u4.state", int'(b4.state), 1 << m4.p);
      chk("u4.idx", int'(b4.idx), m4.p);
      chk("u4.wrap", int'(b4.wrap), int'(m4.wrap));
      chk("u4.err", int'(b4.err), int'(m4.err));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic chk_rst_vals(string tag);
    chk({tag, ".u3.state"}, int'(b3.state), 1);
    chk({tag, ".u3.idx"}, int'(b3.idx), 0);
    chk({tag, ".u3.wrap"}, int'(b3.wrap), 0);
    chk({tag, ".u3.err"}, int'(b3.err), 0);
    chk({tag, ".u4.state"}, int'(b4.state), 4);
    chk({tag, ".u4.idx"}, int'(b4.idx), 2);
    chk({tag, ".u5.state"}, int'(b5.state), 1);
    chk({tag, ".u5.idx"}, int'(b5.idx), 0);
    chk({tag, ".u5.err"}, int'(b5.err), 0);
  endtask

  initial begin
    int seq_up[3];
    int seq_dn[3];
    int prev, cnt, wc, last;
    seq_up = '{2, 4, 1};
    seq_dn = '{4, 2, 1};

    tbl[0]  = '{1, 1, 0, 0, 16, 4, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 16, 4, 0, 0};
    tbl[2]  = '{0, 1, 1, 3,  8, 3, 0, 0};
    tbl[3]  = '{0, 1, 1, 6,  8, 3, 0, 1};
    tbl[4]  = '{0, 1, 0, 0,  8, 3, 0, 0};
    tbl[5]  = '{1, 0, 0, 0,  8, 3, 0, 0};
    tbl[6]  = '{0, 0, 0, 0,  8, 3, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,  4, 2, 0, 0};
    tbl[8]  = '{0, 1, 1, 0,  1, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 0,  1, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0,  1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 16, 4, 1, 0};
    tbl[12] = '{0, 1, 1, 7, 16, 4, 0, 1};
    tbl[13] = '{0, 1, 1, 4, 16, 4, 0, 0};

    rst = 1'b1;
    b3.step_in = 0; b3.dir = 1; b3.load = 0; b3.load_idx = '0;
    b4.step_in = 0; b4.dir = 1; b4.load = 0; b4.load_idx = '0;
    b5.step_in = 0; b5.dir = 1; b5.load = 0; b5.load_idx = '0;
    #1 rst = 1'b0;
    #2 chk_rst_vals("async_rst");
    @(negedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 10; i++) tick();
    chk("idle.u3.state", int'(b3.state), 1);

    // three edge-mode pulses each direction, latency 3 edges
    for (int d = 1; d >= 0; d--) begin
      b3.dir = d[0];
      wc = 0;
      for (int k = 0; k < 3; k++) begin
        if (d == 1) prev = (k == 0) ? 1 : seq_up[k-1];
        else prev = (k == 0) ? 1 : seq_dn[k-1];
        b3.step_in = 1;
        for (int j = 1; j <= 8; j++) begin
          if (j == 5) b3.step_in = 0;
          tick();
          if (b3.wrap) wc++;
          if (j == 2) chk("pulse.lat2", int'(b3.state), prev);
          if (j == 3) begin
            chk("pulse.lat3", int'(b3.state),
                (d == 1) ? seq_up[k] : seq_dn[k]);
            chk("pulse.wrap", int'(b3.wrap),
                ((d == 1 && k == 2) || (d == 0 && k == 0)) ? 1 : 0);
          end
        end
      end
      chk("pulse.wrap_count", wc, 1);
    end

    // long hold in edge mode: exactly one advance
    b3.dir = 1;
    b3.step_in = 1;
    cnt = 0;
    last = int'(b3.state);
    for (int i = 0; i < 24; i++) begin
      if (i == 20) b3.step_in = 0;
      tick();
      if (int'(b3.state) != last) cnt++;
      last = int'(b3.state);
    end
    chk("hold.adv_count", cnt, 1);
    chk("hold.u3.state", int'(b3.state), 2);

    // level mode: four advances for four high cycles
    b5.dir = 1;
    b5.step_in = 1;
    wc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) b5.step_in = 0;
      tick();
      if (b5.wrap) wc++;
    end
    chk("level.u5.state", int'(b5.state), 16);
    chk("level.wrap_count", wc, 0);

    for (int i = 0; i < 14; i++) begin
      b5.step_in = tbl[i].st;
      b5.dir = tbl[i].dr;
      b5.load = tbl[i].ld;
      b5.load_idx = 3'(tbl[i].li);
      tick();
      chk($sformatf("tbl%0d.state", i), int'(b5.state), tbl[i].es);
      chk($sformatf("tbl%0d.idx", i), int'(b5.idx), tbl[i].ei);
      chk($sformatf("tbl%0d.wrap", i), int'(b5.wrap), int'(tbl[i].ew));
      chk($sformatf("tbl%0d.err", i), int'(b5.err), int'(tbl[i].ee));
    end
    b5.load = 0;

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) b3.step_in = ~b3.step_in;
      if ($urandom_range(0, 3) == 0) b4.step_in = ~b4.step_in;
      if ($urandom_range(0, 3) == 0) b5.step_in = ~b5.step_in;
      b3.dir = 1'($urandom);
      b4.dir = 1'($urandom);
      b5.dir = 1'($urandom);
      b3.load = ($urandom_range(0, 9) == 0);
      b4.load = ($urandom_range(0, 9) == 0);
      b5.load = ($urandom_range(0, 9) == 0);
      b3.load_idx = 2'($urandom);
      b4.load_idx = 2'($urandom);
      b5.load_idx = 3'($urandom);
      tick();
    end
    b3.load = 0; b4.load = 0; b5.load = 0;
    b3.step_in = 0; b4.step_in = 0; b5.step_in = 0;
    for (int i = 0; i < 4; i++) tick();

    // corrupt u4 state; model cannot follow until next reset
    chk4 = 1'b0;
    force u4.r_state = 4'b0110;
    #1 release u4.r_state;
    tick();
    chk("recov.state", int'(b4.state), 4);
    chk("recov.idx", int'(b4.idx), 2);
    chk("recov.err", int'(b4.err), 1);
    chk("recov.wrap", int'(b4.wrap), 0);
    tick();
    chk("recov.err_clr", int'(b4.err), 0);
    chk("recov.hold", int'(b4.state), 4);

    // reset mid-stream with step high: no stale advance
    b3.dir = 1; b4.dir = 1; b5.dir = 1;
    b3.step_in = 1; b4.step_in = 1; b5.step_in = 1;
    tick();
    tick();
    #2 rst = 1'b0;
    #1 chk_rst_vals("mid_rst");
    #1 rst = 1'b1;
    chk4 = 1'b1;
    tick();
    tick();
    chk_rst_vals("post_rst");
    tick();
    chk("post_rst.u3.adv", int'(b3.state), 2);
    chk("post_rst.u4.adv", int'(b4.state), 8);
    chk("post_rst.u5.adv", int'(b5.state), 2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
